traffic_injector: RTL

//  Parametrised PE traffic source for an XxY mesh NoC. Generates single-flit packets with a selectable

---
 rtl/traffic_injector.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/traffic_injector.sv
`default_nettype none
// ============================================================================
// Module   : traffic_injector
// Brief    : Single-flit mesh NoC traffic source with patterned destinations
//            and LFSR-driven random inter-packet gaps, one instance per node.
// Revision : 1.0  initial release
// ============================================================================
module traffic_injector #(
    parameter int          X_ID       = 0,
    parameter int          Y_ID       = 0,
    parameter int          MESH_X     = 5,
    parameter int          MESH_Y     = 5,
    parameter int          MODE       = 0,
    parameter int          HOT_X      = 2,
    parameter int          HOT_Y      = 2,
    parameter int          DELAY_BITS = 4,
    parameter int          MAX_PKTS   = 1023,
    parameter logic [31:0] SEED       = 32'h1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        DnStrFull,
    input  logic        GntDnStr,
    output logic        ReqDnStr,
    output logic [31:0] PacketOut,
    output logic [15:0] pkt_count,
    output logic [31:0] cycle_count,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_PREP     = 2'd1,
        S_GAP      = 2'd2,
        S_WAIT_GNT = 2'd3
    } state_t;

    localparam logic [31:0] c_POLY      = 32'h8020_0003;
    localparam logic [2:0]  c_X         = 3'(X_ID);
    localparam logic [2:0]  c_Y         = 3'(Y_ID);
    localparam logic [2:0]  c_HOT_X     = 3'(HOT_X);
    localparam logic [2:0]  c_HOT_Y     = 3'(HOT_Y);
    localparam logic [7:0]  c_MX8       = 8'(MESH_X);
    localparam logic [7:0]  c_MY8       = 8'(MESH_Y);
    localparam logic [2:0]  c_MX_LAST   = 3'(MESH_X - 1);
    localparam logic [2:0]  c_TR_X      = 3'(Y_ID);
    localparam logic [2:0]  c_TR_Y      = 3'(X_ID);
    localparam logic [2:0]  c_BC_X      = 3'(MESH_X - 1 - X_ID);
    localparam logic [2:0]  c_BC_Y      = 3'(MESH_Y - 1 - Y_ID);
    localparam logic [5:0]  c_MODULE_ID = {c_X, c_Y};
    localparam logic [7:0]  c_SRC       = {1'b0, c_X, 1'b0, c_Y};
    localparam logic [31:0] c_MAX       = 32'(MAX_PKTS);
    localparam logic [DELAY_BITS-1:0] c_ONE = DELAY_BITS'(1);
    // Fixed patterns that map back onto this node can never produce traffic.
    localparam logic c_SELF_DEST =
        ((MODE == 1) && (X_ID == Y_ID)) ||
        ((MODE == 2) && (MESH_X - 1 - X_ID == X_ID) && (MESH_Y - 1 - Y_ID == Y_ID));
    localparam logic c_HOT_VALID = !((HOT_X == X_ID) && (HOT_Y == Y_ID));

    state_t                 r_state,    w_stateNext;
    logic [31:0]            r_lfsr,     w_lfsrNext;
    logic [DELAY_BITS-1:0]  r_delay,    w_delayNext;
    logic [DELAY_BITS-1:0]  r_count,    w_countNext;
    logic                   r_req,      w_reqNext;
    logic [31:0]            r_pkt,      w_pktNext;
    logic [3:0]             r_xField,   w_xFieldNext;
    logic [3:0]             r_yField,   w_yFieldNext;
    logic [9:0]             r_pktId,    w_pktIdNext;
    logic [15:0]            r_pktCount, w_pktCountNext;
    logic                   r_done,     w_doneNext;
    logic [31:0]            r_cycle;

    logic [31:0] w_lfsrStep;
    logic [2:0]  w_rndX, w_rndY, w_uniX, w_uniY, w_dstX, w_dstY;
    logic [15:0] w_pktCountInc;

    assign w_lfsrStep    = {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? c_POLY : 32'h0);
    assign w_pktCountInc = (r_pktCount == 16'hFFFF) ? r_pktCount : r_pktCount + 16'd1;

    // Random destination; a self hit is nudged one column east (wrapping).
    assign w_rndX = 3'(r_lfsr[15:8] % c_MX8);
    assign w_rndY = 3'(r_lfsr[23:16] % c_MY8);
    assign w_uniY = w_rndY;
    assign w_uniX = (w_rndX == c_X && w_rndY == c_Y) ?
                    ((w_rndX == c_MX_LAST) ? 3'd0 : w_rndX + 3'd1) : w_rndX;

    always_comb begin
        w_dstX = w_uniX;
        w_dstY = w_uniY;
        case (MODE)
            1: begin
                w_dstX = c_TR_X;
                w_dstY = c_TR_Y;
            end
            2: begin
                w_dstX = c_BC_X;
                w_dstY = c_BC_Y;
            end
            3: begin
                if (c_HOT_VALID && r_lfsr[31:30] == 2'b00) begin
                    w_dstX = c_HOT_X;
                    w_dstY = c_HOT_Y;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        w_stateNext    = r_state;
        w_lfsrNext     = r_lfsr;
        w_delayNext    = r_delay;
        w_countNext    = r_count;
        w_reqNext      = r_req;
        w_pktNext      = r_pkt;
        w_xFieldNext   = r_xField;
        w_yFieldNext   = r_yField;
        w_pktIdNext    = r_pktId;
        w_pktCountNext = r_pktCount;
        w_doneNext     = r_done | c_SELF_DEST;
        case (r_state)
            S_IDLE: begin
                if (enable && !r_done && !c_SELF_DEST) begin
                    w_stateNext = S_PREP;
                    w_lfsrNext  = w_lfsrStep;
                    w_delayNext = w_lfsrStep[DELAY_BITS-1:0];
                    w_countNext = '0;
                end
            end
            S_PREP: begin
                // Direction bit: x set when heading east, y set when heading north.
                w_xFieldNext = {(w_dstX > c_X), w_dstX};
                w_yFieldNext = {(w_dstY < c_Y), w_dstY};
                w_stateNext  = S_GAP;
            end
            S_GAP: begin
                if (r_count != r_delay) begin
                    w_countNext = r_count + c_ONE;
                end else if (!DnStrFull) begin
                    w_reqNext   = 1'b1;
                    w_pktNext   = {r_xField, r_yField, c_SRC, r_pktId, c_MODULE_ID};
                    w_stateNext = S_WAIT_GNT;
                end
            end
            S_WAIT_GNT: begin
                if (GntDnStr) begin
                    w_reqNext      = 1'b0;
                    w_pktCountNext = w_pktCountInc;
                    w_pktIdNext    = r_pktId + 10'd1;
                    if (c_MAX != 32'd0 && {16'd0, w_pktCountInc} == c_MAX)
                        w_doneNext = 1'b1;
                    w_stateNext    = S_IDLE;
                end
            end
            default: w_stateNext = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_lfsr     <= SEED;
            r_delay    <= '0;
            r_count    <= '0;
            r_req      <= 1'b0;
            r_pkt      <= '0;
            r_xField   <= '0;
            r_yField   <= '0;
            r_pktId    <= '0;
            r_pktCount <= '0;
            r_done     <= 1'b0;
            r_cycle    <= '0;
        end else begin
            r_state    <= w_stateNext;
            r_lfsr     <= w_lfsrNext;
            r_delay    <= w_delayNext;
            r_count    <= w_countNext;
            r_req      <= w_reqNext;
            r_pkt      <= w_pktNext;
            r_xField   <= w_xFieldNext;
            r_yField   <= w_yFieldNext;
            r_pktId    <= w_pktIdNext;
            r_pktCount <= w_pktCountNext;
            r_done     <= w_doneNext;
            r_cycle    <= r_cycle + 32'd1;
        end
    end

    assign ReqDnStr    = r_req;
    assign PacketOut   = r_pkt;
    assign pkt_count   = r_pktCount;
    assign cycle_count = r_cycle;
    assign done        = r_done;

endmodule
`default_nettype wire
